// File: rtl/arb_pkg.sv
// Shared types and default widths for the IF/DM memory arbiter.
package arb_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef enum logic {
    REQ_IF,
    REQ_DM
  } requester_t;

  // Saturating 16-bit increment used by the optional statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive DM grants while IF waits; force_if asserts once STARVE_MAX is reached.
module arb_starve_counter #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic if_req,
  input  logic if_grant,
  input  logic dm_grant,
  output logic force_if
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (if_grant || !if_req) begin
      cnt_next = '0;
    end else if (dm_grant && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign force_if = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and data requesters.
// Optional statistics counters are enabled by defining ARB_STATS_EN.
module memory_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_wen,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_if_grants,
  output logic [15:0]       stat_dm_grants,
  output logic [15:0]       stat_conflicts
`endif
);

  arb_state_t        state_reg, state_next;
  requester_t        winner_reg, winner_next;
  logic              mem_en_reg, mem_en_next;
  logic              mem_wen_reg, mem_wen_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic              if_ack_reg, if_ack_next;
  logic              dm_ack_reg, dm_ack_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] dm_rdata_reg, dm_rdata_next;
  logic              grant_if;
  logic              grant_dm;
  logic              force_if;

  arb_starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .clr     (clr),
    .if_req  (if_req),
    .if_grant(grant_if),
    .dm_grant(grant_dm),
    .force_if(force_if)
  );

  always_comb begin
    state_next     = state_reg;
    winner_next    = winner_reg;
    mem_en_next    = 1'b0;
    mem_wen_next   = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_ack_next    = 1'b0;
    dm_ack_next    = 1'b0;
    if_rdata_next  = if_rdata_reg;
    dm_rdata_next  = dm_rdata_reg;
    grant_if       = 1'b0;
    grant_dm       = 1'b0;

    case (state_reg)
      IDLE: begin
        // DM normally wins; a starved IF takes the next conflict.
        if (dm_req && !(if_req && force_if)) begin
          grant_dm = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end

        if (grant_dm) begin
          winner_next    = REQ_DM;
          mem_en_next    = 1'b1;
          mem_wen_next   = dm_wen;
          mem_addr_next  = dm_addr;
          mem_wdata_next = dm_wdata;
          state_next     = ACCESS;
        end else if (grant_if) begin
          winner_next    = REQ_IF;
          mem_en_next    = 1'b1;
          mem_addr_next  = if_addr;
          state_next     = ACCESS;
        end
      end

      ACCESS: begin
        state_next = RESP;
      end

      RESP: begin
        if (winner_reg == REQ_DM) begin
          dm_rdata_next = mem_rdata;
          dm_ack_next   = 1'b1;
        end else begin
          if_rdata_next = mem_rdata;
          if_ack_next   = 1'b1;
        end
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg     <= IDLE;
      winner_reg    <= REQ_IF;
      mem_en_reg    <= 1'b0;
      mem_wen_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_ack_reg    <= 1'b0;
      dm_ack_reg    <= 1'b0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      winner_reg    <= winner_next;
      mem_en_reg    <= mem_en_next;
      mem_wen_reg   <= mem_wen_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_ack_reg    <= if_ack_next;
      dm_ack_reg    <= dm_ack_next;
      if_rdata_reg  <= if_rdata_next;
      dm_rdata_reg  <= dm_rdata_next;
    end
  end

  assign mem_en    = mem_en_reg;
  assign mem_wen   = mem_wen_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign if_ack    = if_ack_reg;
  assign dm_ack    = dm_ack_reg;
  assign if_rdata  = if_rdata_reg;
  assign dm_rdata  = dm_rdata_reg;

  // A requester is not stalled in the cycle its ack is presented.
  assign stall = (if_req && !if_ack_reg) || (dm_req && !dm_ack_reg);

`ifdef ARB_STATS_EN
  logic [2:0]  stat_inc;
  logic [15:0] stat_val [3];

  assign stat_inc = {(state_reg == IDLE) && if_req && dm_req, grant_dm, grant_if};

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_stat
    logic [15:0] cnt_reg;

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        cnt_reg <= '0;
      end else if (stat_inc[gi]) begin
        cnt_reg <= sat_inc(cnt_reg);
      end
    end

    assign stat_val[gi] = cnt_reg;
  end

  assign stat_if_grants = stat_val[0];
  assign stat_dm_grants = stat_val[1];
  assign stat_conflicts = stat_val[2];
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural 1-cycle-latency memory.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic        if_req;
  logic [7:0]  if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_wen;
  logic [7:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_en;
  logic        mem_wen;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall;
`ifdef ARB_STATS_EN
  logic [15:0] stat_if_grants;
  logic [15:0] stat_dm_grants;
  logic [15:0] stat_conflicts;
`endif

  int checks = 0;
  int errors = 0;

  memory_arbiter dut (
    .clk      (clk),
    .clr      (clr),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .dm_req   (dm_req),
    .dm_wen   (dm_wen),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ack   (dm_ack),
    .mem_en   (mem_en),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall    (stall)
`ifdef ARB_STATS_EN
    ,
    .stat_if_grants(stat_if_grants),
    .stat_dm_grants(stat_dm_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  // Memory: preset contents from init_word, overlaid by anything written.
  bit          written [256];
  logic [31:0] wr_mem  [256];

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'h04) ? 32'h2008_0005 : {24'hA5A5A5, a};
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen) begin
        wr_mem[mem_addr]  <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end
      mem_rdata <= written[mem_addr] ? wr_mem[mem_addr] : init_word(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_wen = 1'b0; dm_addr = '0; dm_wdata = '0;
    step(); step();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_dm_ack", dm_ack, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mem_addr", mem_addr, 0);
    clr = 1'b0;
    step();

    // 1: IF fetch of word 4
    if_req = 1'b1; if_addr = 8'h04;
    #1 chk("t1_stall_pending", stall, 1);
    step();
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_addr", mem_addr, 32'h04);
    chk("t1_mem_wen", mem_wen, 0);
    step();
    chk("t1_mem_en_drop", mem_en, 0);
    chk("t1_no_early_ack", if_ack, 0);
    step();
    chk("t1_if_ack", if_ack, 1);
    chk("t1_if_rdata", if_rdata, 32'h2008_0005);
    chk("t1_stall_ack", stall, 0);
    if_req = 1'b0;
    step();
    chk("t1_ack_pulse", if_ack, 0);

    // 2: DM write then read back
    dm_req = 1'b1; dm_wen = 1'b1; dm_addr = 8'h10; dm_wdata = 32'hDEAD_BEEF;
    step();
    chk("t2_wr_mem_en", mem_en, 1);
    chk("t2_wr_mem_wen", mem_wen, 1);
    chk("t2_wr_mem_addr", mem_addr, 32'h10);
    chk("t2_wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    chk("t2_wr_wen_1cyc", mem_wen, 0);
    step();
    chk("t2_wr_ack", dm_ack, 1);
    dm_wen = 1'b0;
    step();
    chk("t2_rd_grant_wen", mem_wen, 0);
    chk("t2_rd_ack_pulse", dm_ack, 0);
    step(); step();
    chk("t2_rd_ack", dm_ack, 1);
    chk("t2_rd_data", dm_rdata, 32'hDEAD_BEEF);
    dm_req = 1'b0;
    step();

    // 3: simultaneous requests, DM first
    if_req = 1'b1; if_addr = 8'h04;
    dm_req = 1'b1; dm_addr = 8'h10;
    step();
    chk("t3_dm_wins", mem_addr, 32'h10);
    step(); step();
    chk("t3_dm_ack", dm_ack, 1);
    chk("t3_if_not_ack", if_ack, 0);
    chk("t3_stall_if", stall, 1);
    dm_req = 1'b0;
    step();
    chk("t3_if_grant", mem_addr, 32'h04);
    chk("t3_stall_if2", stall, 1);
    step();
    chk("t3_stall_if3", stall, 1);
    step();
    chk("t3_if_ack", if_ack, 1);
    chk("t3_if_rdata", if_rdata, 32'h2008_0005);
    chk("t3_stall_clear", stall, 0);
    if_req = 1'b0;
    step();

    // 4: DM held, IF starved for STARVE_MAX grants
    if_req = 1'b1; if_addr = 8'h04;
    dm_req = 1'b1; dm_addr = 8'h10;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t4_dm_grant%0d", k), mem_addr, 32'h10);
      step(); step();
      chk($sformatf("t4_dm_ack%0d", k), dm_ack, 1);
    end
    step();
    chk("t4_if_forced", mem_addr, 32'h04);
    step(); step();
    chk("t4_if_ack", if_ack, 1);
    chk("t4_if_dm_quiet", dm_ack, 0);
    step();
    chk("t4_cnt_reset_dm_wins", mem_addr, 32'h10);
    if_req = 1'b0; dm_req = 1'b0;
    step(); step();
    chk("t4_dropped_still_ack", dm_ack, 1);
    step();
    chk("t4_no_retry_en", mem_en, 0);
    chk("t4_no_retry_ack", dm_ack, 0);

    // 5: clr during ACCESS aborts a write
    dm_req = 1'b1; dm_wen = 1'b1; dm_addr = 8'h20; dm_wdata = 32'h1234_5678;
    step();
    chk("t5_grant", mem_en, 1);
    #1 clr = 1'b1;
    #1;
    chk("t5_async_en", mem_en, 0);
    chk("t5_async_wen", mem_wen, 0);
    dm_req = 1'b0; dm_wen = 1'b0;
    step();
    clr = 1'b0;
    step(); step();
    chk("t5_no_ack", dm_ack, 0);
    chk("t5_idle_en", mem_en, 0);
    dm_req = 1'b1;
    step();
    chk("t5_regrant", mem_en, 1);
    step(); step();
    chk("t5_ack", dm_ack, 1);
    chk("t5_write_aborted", dm_rdata, 32'hA5A5_A520);
    dm_req = 1'b0;
    step();

`ifdef ARB_STATS_EN
    // 6: 3 conflicts, 2 IF grants, 5 DM grants
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t6_rst_conf", stat_conflicts, 0);
    for (int k = 0; k < 2; k++) begin
      if_req = 1'b1; dm_req = 1'b1;
      step(); step(); step();
      dm_req = 1'b0;
      step(); step(); step();
      if_req = 1'b0;
    end
    if_req = 1'b1; dm_req = 1'b1;
    step();
    if_req = 1'b0;
    repeat (8) step();
    dm_req = 1'b0;
    step();
    chk("t6_conflicts", stat_conflicts, 3);
    chk("t6_if_grants", stat_if_grants, 2);
    chk("t6_dm_grants", stat_dm_grants, 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
